// File: rtl/fifo8x4_fwft_if.sv
// Producer/consumer handshake bundle for the 8x4 FWFT FIFO; master drives requests, slave is the FIFO.
interface fifo8x4_fwft_if #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 3
);
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  full;
  logic                  empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output wr_en, wr_data, rd_en,
    input  rd_data, rd_ptr, full, empty, count, overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en,
    output rd_data, rd_ptr, full, empty, count, overflow, underflow
  );
endinterface

// File: rtl/fifo8x4_fwft.sv
// 8x4 first-word-fall-through FIFO: head word is combinational from mem[rd_ptr], zero read latency.
// Pushes while full (without a same-cycle pop) and pops while empty are dropped with a one-cycle strobe.
module fifo8x4_fwft #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 3
) (
  input  logic           clk,
  input  logic           reset_n,
  fifo8x4_fwft_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_FULL = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;
  logic                  full;
  logic                  empty;
  logic                  push_ok;
  logic                  pop_ok;
  logic [DATA_WIDTH-1:0] head;

  assign full  = (count == CNT_FULL);
  assign empty = (count == '0);

  // A pop frees the slot the push targets when full, so a same-cycle pop unblocks the push.
  assign pop_ok  = bus.rd_en & ~empty;
  assign push_ok = bus.wr_en & (~full | pop_ok);

  // 8-way read-select stage driven by the head pointer.
  always_comb begin
    head = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_ptr == ADDR_WIDTH'(i)) head = mem[i];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= bus.wr_data;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (pop_ok) rd_ptr <= rd_ptr + PTR_ONE;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      overflow  <= bus.wr_en & full & ~pop_ok;
      underflow <= bus.rd_en & empty;
    end
  end

  assign bus.rd_data   = head;
  assign bus.rd_ptr    = rd_ptr;
  assign bus.full      = full;
  assign bus.empty     = empty;
  assign bus.count     = count;
  assign bus.overflow  = overflow;
  assign bus.underflow = underflow;
endmodule

// File: tb/tb_fifo8x4_fwft.sv
// Directed bench for fifo8x4_fwft: hand-computed expectations for ordering, full/empty edges, strobes and async reset.
module tb_fifo8x4_fwft;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  fifo8x4_fwft_if bus ();

  fifo8x4_fwft dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    step();
  endtask

  task automatic push(input logic [3:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_data = d;
    bus.rd_en   = 1'b0;
    step();
    bus.wr_en = 1'b0;
  endtask

  task automatic pop_chk(input string tag, input logic [3:0] exp);
    chk(tag, 8'(bus.rd_data), 8'(exp));
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b1;
    step();
    bus.rd_en = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.wr_en   = 1'b0;
    bus.rd_en   = 1'b0;
    bus.wr_data = 4'h0;
    repeat (2) step();
    reset_n = 1'b1;
    repeat (3) idle();
    chk("rst_empty", 8'(bus.empty), 8'd1);
    chk("rst_full", 8'(bus.full), 8'd0);
    chk("rst_count", 8'(bus.count), 8'd0);
    chk("rst_rd_ptr", 8'(bus.rd_ptr), 8'd0);
    chk("rst_rd_data", 8'(bus.rd_data), 8'h0);
    chk("rst_ovf", 8'(bus.overflow), 8'd0);
    chk("rst_udf", 8'(bus.underflow), 8'd0);

    // Ordering and FWFT latency.
    push(4'h3);
    chk("fwft_data", 8'(bus.rd_data), 8'h3);
    chk("fwft_empty", 8'(bus.empty), 8'd0);
    chk("cnt1", 8'(bus.count), 8'd1);
    push(4'hA);
    chk("cnt2", 8'(bus.count), 8'd2);
    push(4'h5);
    chk("cnt3", 8'(bus.count), 8'd3);
    pop_chk("pop_3", 4'h3);
    chk("cnt_dn2", 8'(bus.count), 8'd2);
    pop_chk("pop_A", 4'hA);
    chk("cnt_dn1", 8'(bus.count), 8'd1);
    pop_chk("pop_5", 4'h5);
    chk("cnt_dn0", 8'(bus.count), 8'd0);
    chk("drain_empty", 8'(bus.empty), 8'd1);
    chk("drain_rd_ptr", 8'(bus.rd_ptr), 8'd3);

    // Fill (write pointer wraps from 7 to 0), overflow, drain.
    for (int i = 0; i < 8; i++) push(4'(i));
    chk("fill_full", 8'(bus.full), 8'd1);
    chk("fill_count", 8'(bus.count), 8'd8);
    push(4'hF);
    chk("ovf_strobe", 8'(bus.overflow), 8'd1);
    chk("ovf_count", 8'(bus.count), 8'd8);
    idle();
    chk("ovf_clear", 8'(bus.overflow), 8'd0);
    for (int i = 0; i < 8; i++) pop_chk("drain_seq", 4'(i));
    chk("drain2_empty", 8'(bus.empty), 8'd1);

    // Simultaneous push/pop while full.
    for (int i = 0; i < 8; i++) push(4'(i));
    chk("full_head", 8'(bus.rd_data), 8'h0);
    bus.wr_en   = 1'b1;
    bus.wr_data = 4'hC;
    bus.rd_en   = 1'b1;
    step();
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    chk("both_full_count", 8'(bus.count), 8'd8);
    chk("both_full_ovf", 8'(bus.overflow), 8'd0);
    chk("both_full_head", 8'(bus.rd_data), 8'h1);
    for (int i = 1; i < 8; i++) pop_chk("wrap_seq", 4'(i));
    pop_chk("wrap_last_C", 4'hC);
    chk("wrap_empty", 8'(bus.empty), 8'd1);
    chk("wrap_rd_ptr", 8'(bus.rd_ptr), 8'd4);

    // Simultaneous push/pop while empty: pop rejected, no bypass.
    bus.wr_en   = 1'b1;
    bus.wr_data = 4'h9;
    bus.rd_en   = 1'b1;
    step();
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    chk("both_empty_udf", 8'(bus.underflow), 8'd1);
    chk("both_empty_count", 8'(bus.count), 8'd1);
    chk("both_empty_data", 8'(bus.rd_data), 8'h9);
    chk("both_empty_ovf", 8'(bus.overflow), 8'd0);
    idle();
    chk("udf_clear", 8'(bus.underflow), 8'd0);
    pop_chk("pop_9", 4'h9);
    bus.rd_en = 1'b1;
    step();
    bus.rd_en = 1'b0;
    chk("pop_empty_udf", 8'(bus.underflow), 8'd1);
    chk("pop_empty_rd_ptr", 8'(bus.rd_ptr), 8'd5);
    chk("pop_empty_count", 8'(bus.count), 8'd0);

    // Asynchronous reset mid-cycle.
    for (int i = 1; i <= 5; i++) push(4'(i));
    chk("pre_rst_count", 8'(bus.count), 8'd5);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_count", 8'(bus.count), 8'd0);
    chk("arst_empty", 8'(bus.empty), 8'd1);
    chk("arst_rd_ptr", 8'(bus.rd_ptr), 8'd0);
    chk("arst_rd_data", 8'(bus.rd_data), 8'h0);
    step();
    reset_n = 1'b1;
    push(4'h6);
    chk("post_rst_data", 8'(bus.rd_data), 8'h6);
    chk("post_rst_count", 8'(bus.count), 8'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fifo8x4_fwft.md
Name: fifo8x4_fwft

Overview:
- 8-entry, 4-bit-wide first-word-fall-through FIFO.
- Its storage array and read pointer drive an 8-way, 4-bit read-select stage: eight entry words plus a 3-bit select in, one 4-bit word out.
- Buffers 4-bit operands/digits between a producer (datapath or keypad logic) and a consumer (display or ALU operand path).
- Occupancy tracking, full/empty flags and one-cycle error strobes are part of the block.

Parameters:
- DATA_WIDTH, 4, bits per entry (fixed at 4; other values unsupported).
- ADDR_WIDTH, 3, pointer width; depth = 2**ADDR_WIDTH = 8 (fixed).

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- wr_en  input  1  push request.
- wr_data  input  4  data to push.
- rd_en  input  1  pop request.
- rd_data  output  4  head entry (combinational from mem[rd_ptr]; valid when empty=0).
- rd_ptr  output  3  current head index, the select for the read stage.
- full  output  1  count==8.
- empty  output  1  count==0.
- count  output  4  occupancy 0..8.
- overflow  output  1  one-cycle strobe, push rejected.
- underflow  output  1  one-cycle strobe, pop rejected.

Behaviour:
- Reset (reset_n=0, asynchronous, any time including mid-operation):
  - wr_ptr=0, rd_ptr=0, count=0, all 8 entries=0.
  - empty=1, full=0, overflow=0, underflow=0, rd_data=0.
  - Held while reset_n low; normal operation from the first rising edge after deassertion.
- Registered state: mem[0..7], wr_ptr, rd_ptr, count, overflow, underflow. full and empty decode combinationally from count.
- Push accepted when wr_en=1 and (full=0 or pop accepted same cycle):
  - mem[wr_ptr]<=wr_data; wr_ptr<=wr_ptr+1 (mod 8, 7 wraps to 0).
- Pop accepted when rd_en=1 and empty=0:
  - rd_ptr<=rd_ptr+1 (mod 8).
  - The popped value is the rd_data presented in that cycle (FWFT, zero read latency).
- Write-to-read latency: a word pushed at edge N appears on rd_data after edge N when the FIFO was empty (empty deasserts after edge N).
- count update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Simultaneous push and pop:
  - Empty FIFO: pop rejected (underflow=1), push accepted, count becomes 1. No bypass; the new word is not consumed that cycle.
  - Full FIFO: both accepted, count stays 8, overflow=0. Head advances and the freed slot (old rd_ptr == wr_ptr) is written.
  - Otherwise: both accepted.
- overflow <= wr_en & full & ~(pop accepted), for exactly one cycle. Rejected data is discarded and state is unchanged.
- underflow <= rd_en & empty, for one cycle. Pointers are unchanged.
- Ports not driving the pushed or popped slots do not change. Entries are not cleared on pop; stale data remains but is unobservable while empty=1.
- rd_data while empty=1 is mem[rd_ptr], i.e. stale; consumers gate on empty.

Test Plan:
- Reset then idle 3 cycles -> empty=1, full=0, count=0, rd_ptr=0, rd_data=4'h0, no strobes.
- Push 4'h3, 4'hA, 4'h5 on consecutive cycles, then pop 3 -> rd_data 3, A, 5 in order. count 1,2,3 then 2,1,0. empty=1 at end, rd_ptr=3.
- Push 8 words 4'h0..4'h7 -> full=1, count=8. Ninth push 4'hF -> overflow=1 for one cycle, count=8. Draining all 8 yields 0..7 (F absent).
- From full, push 4'hC with simultaneous pop -> popped 4'h0, count=8, no overflow. After draining, the last word is C (pointer wrap 7->0 verified).
- Empty FIFO, rd_en=1 and wr_en=1 with 4'h9 -> underflow=1, count=1, rd_data=9 next cycle. Pop alone on empty -> underflow=1, rd_ptr unchanged.
- Push 5 words, assert reset_n=0 asynchronously mid-cycle -> count=0, empty=1, rd_ptr=0 immediately without a clock edge. After release, push 4'h6 -> rd_data=6.
